// File: rtl/arquitetura_button_pio.sv
// Avalon-MM push-button/switch input port: per-channel synchroniser, debounce,
// edge capture with write-1-to-clear, and a maskable level interrupt.
module arquitetura_button_pio #(
  parameter int unsigned WIDTH           = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned EDGE_TYPE       = 1,
  parameter bit          IDLE_LEVEL      = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  localparam int unsigned      CW       = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CW-1:0]    CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [WIDTH-1:0] IDLE_VEC = {WIDTH{IDLE_LEVEL}};

  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_MASK = 2'd1;
  localparam logic [1:0] ADDR_RAW  = 2'd2;
  localparam logic [1:0] ADDR_CAP  = 2'd3;

  logic [WIDTH-1:0] sync1_q, sync2_q;
  logic [WIDTH-1:0] stable_q, stable_d;
  logic [CW-1:0]    cnt_q [WIDTH];
  logic [CW-1:0]    cnt_d [WIDTH];
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [WIDTH-1:0] cap_q, cap_d;
  logic [31:0]      readdata_q, readdata_d;
  logic             irq_q, irq_d;

  logic             wr_c;
  logic [WIDTH-1:0] set_c;
  logic [WIDTH-1:0] clr_c;

  // Does a newly accepted level count as a capturable edge?
  function automatic logic edge_hit(input logic new_lvl);
    case (EDGE_TYPE)
      0:       edge_hit = new_lvl;
      1:       edge_hit = ~new_lvl;
      default: edge_hit = 1'b1;
    endcase
  endfunction

  // Debounce: accept sync2 once it has differed from stable for DEBOUNCE_CYCLES cycles
  always_comb begin
    stable_d = stable_q;
    set_c    = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != stable_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          stable_d[i] = sync2_q[i];
          set_c[i]    = edge_hit(sync2_q[i]);
        end else begin
          cnt_d[i] = cnt_q[i] + CW'(1);
        end
      end
    end
  end

  // Register file, capture update and read mux
  always_comb begin
    wr_c   = chipselect & write;
    mask_d = mask_q;
    clr_c  = '0;
    if (wr_c && (address == ADDR_MASK)) mask_d = writedata[WIDTH-1:0];
    if (wr_c && (address == ADDR_CAP))  clr_c  = writedata[WIDTH-1:0];
    // A capture set on the same cycle as its clear survives
    cap_d = (cap_q & ~clr_c) | set_c;
    irq_d = |(cap_q & mask_q);
    case (address)
      ADDR_DATA: readdata_d = 32'(stable_q);
      ADDR_MASK: readdata_d = 32'(mask_q);
      ADDR_RAW:  readdata_d = 32'(sync2_q);
      ADDR_CAP:  readdata_d = 32'(cap_q);
      default:   readdata_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q    <= IDLE_VEC;
      sync2_q    <= IDLE_VEC;
      stable_q   <= IDLE_VEC;
      mask_q     <= '0;
      cap_q      <= '0;
      readdata_q <= '0;
      irq_q      <= 1'b0;
      for (int i = 0; i < int'(WIDTH); i++) cnt_q[i] <= '0;
    end else begin
      sync1_q    <= in_port;
      sync2_q    <= sync1_q;
      stable_q   <= stable_d;
      mask_q     <= mask_d;
      cap_q      <= cap_d;
      readdata_q <= readdata_d;
      irq_q      <= irq_d;
      for (int i = 0; i < int'(WIDTH); i++) cnt_q[i] <= cnt_d[i];
    end
  end

  if (WIDTH < 32) begin : g_wdata_hi
    logic unused_wdata_hi;
    assign unused_wdata_hi = ^writedata[31:WIDTH];
  end

  assign readdata = readdata_q;
  assign irq      = irq_q;

endmodule

// File: tb/tb_arquitetura_button_pio.sv
// Scoreboard bench for arquitetura_button_pio: directed scenarios plus random
// traffic, every cycle checked against a behavioural model of the port.
module tb_arquitetura_button_pio;

  localparam int W = 4;
  localparam int D = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [1:0]    address;
  logic          chipselect;
  logic          write;
  logic [31:0]   writedata;
  logic [W-1:0]  in_port;
  logic [31:0]   readdata;
  logic          irq;

  arquitetura_button_pio #(
    .WIDTH(W), .DEBOUNCE_CYCLES(D), .EDGE_TYPE(1), .IDLE_LEVEL(1'b1)
  ) dut (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write(write), .writedata(writedata), .in_port(in_port),
    .readdata(readdata), .irq(irq)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] rd;
    logic        irq;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  // Reference model: the input as seen one and two edges ago, the accepted
  // level, and how many consecutive cycles the delayed input has disagreed.
  logic [W-1:0] m_seen1, m_seen2, m_stable, m_mask, m_cap;
  int           m_run [W];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Predict the outputs after the coming rising edge and advance the model
  task automatic model_step();
    exp_t         e;
    logic [W-1:0] set, clr, nxt;
    if (reset) begin
      m_seen1 = '1; m_seen2 = '1; m_stable = '1; m_mask = '0; m_cap = '0;
      for (int b = 0; b < W; b++) m_run[b] = 0;
      e.rd = '0; e.irq = 1'b0;
    end else begin
      case (address)
        2'd0:    e.rd = {28'd0, m_stable};
        2'd1:    e.rd = {28'd0, m_mask};
        2'd2:    e.rd = {28'd0, m_seen2};
        default: e.rd = {28'd0, m_cap};
      endcase
      e.irq = (m_cap & m_mask) != 0;
      set = '0;
      nxt = m_stable;
      for (int b = 0; b < W; b++) begin
        if (m_seen2[b] != m_stable[b]) begin
          m_run[b] = m_run[b] + 1;
          if (m_run[b] == D) begin
            nxt[b]   = m_seen2[b];
            m_run[b] = 0;
            if (m_seen2[b] == 1'b0) set[b] = 1'b1;
          end
        end else begin
          m_run[b] = 0;
        end
      end
      clr = '0;
      if (chipselect && write && address == 2'd1) m_mask = writedata[W-1:0];
      if (chipselect && write && address == 2'd3) clr = writedata[W-1:0];
      m_cap    = (m_cap & ~clr) | set;
      m_stable = nxt;
      m_seen2  = m_seen1;
      m_seen1  = in_port;
    end
    sb.push_back(e);
  endtask

  task automatic tick();
    model_step();
    @(negedge clk);
  endtask

  task automatic write_reg(input logic [1:0] a, input logic [31:0] d);
    chipselect = 1'b1; write = 1'b1; address = a; writedata = d;
    tick();
    chipselect = 1'b0; write = 1'b0;
  endtask

  // Monitor: readdata/irq are presented every cycle
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("readdata", readdata, e.rd);
        check("irq", {31'd0, irq}, {31'd0, e.irq});
      end
    end
  end

  initial begin
    reset = 1'b1; address = '0; chipselect = 1'b0; write = 1'b0;
    writedata = '0; in_port = '1;
    m_seen1 = '1; m_seen2 = '1; m_stable = '1; m_mask = '0; m_cap = '0;
    for (int b = 0; b < W; b++) m_run[b] = 0;

    // Reset state
    tick(); tick();
    reset = 1'b0;
    address = 2'd0; tick(); tick();
    check("reset_data", readdata, 32'h0000_000F);
    check("reset_irq", {31'd0, irq}, 32'd0);
    address = 2'd3; tick();
    check("reset_cap", readdata, 32'h0);

    // Held falling input on bit0 with mask bit0
    write_reg(2'd1, 32'h1);
    in_port = 4'hE; address = 2'd0;
    repeat (8) tick();
    check("press_data", readdata, 32'h0000_000E);
    check("press_irq", {31'd0, irq}, 32'd1);
    address = 2'd3; tick();
    check("press_cap", readdata, 32'h1);

    // Release, clear, then a 3-cycle glitch on bit1 must be rejected
    in_port = 4'hF; repeat (8) tick();
    write_reg(2'd3, 32'hF);
    in_port = 4'hD; repeat (3) tick();
    in_port = 4'hF; repeat (10) tick();
    address = 2'd0; tick();
    check("glitch_data", readdata, 32'h0000_000F);
    address = 2'd3; tick();
    check("glitch_cap", readdata, 32'h0);
    check("glitch_irq", {31'd0, irq}, 32'd0);

    // Partial clear, then set and clear colliding on bit0
    in_port = 4'hC; repeat (8) tick();
    address = 2'd3; tick();
    check("cap_two", readdata, 32'h3);
    write_reg(2'd3, 32'h1);
    address = 2'd3; tick();
    check("cap_partial_clr", readdata, 32'h2);
    in_port = 4'hD; repeat (8) tick();
    in_port = 4'hC; tick();
    repeat (4) tick();
    write_reg(2'd3, 32'h1);
    address = 2'd3; tick();
    check("set_wins", readdata, 32'h3);

    // Masking controls irq
    in_port = 4'hF; repeat (8) tick();
    write_reg(2'd1, 32'h0);
    write_reg(2'd3, 32'hF);
    in_port = 4'hB; repeat (8) tick();
    address = 2'd3; tick();
    check("mask_cap", readdata, 32'h4);
    check("masked_irq", {31'd0, irq}, 32'd0);
    write_reg(2'd1, 32'h4); tick();
    check("unmask_irq", {31'd0, irq}, 32'd1);
    write_reg(2'd3, 32'h4); tick();
    check("clear_irq", {31'd0, irq}, 32'd0);

    // Reset in the middle of a debounce count on bit2
    in_port = 4'hF; repeat (8) tick();
    in_port = 4'hB; repeat (4) tick();
    reset = 1'b1; tick(); reset = 1'b0;
    address = 2'd0; tick(); tick();
    check("rst_mid_data", readdata, 32'h0000_000F);
    address = 2'd3; tick();
    check("rst_mid_cap", readdata, 32'h0);
    address = 2'd0; tick(); tick();
    check("rst_mid_not_yet", readdata, 32'h0000_000F);
    tick(); tick();
    check("rst_mid_accept", readdata, 32'h0000_000B);

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      for (int b = 0; b < W; b++)
        if ($urandom_range(4) == 0) in_port[b] = ~in_port[b];
      address   = 2'($urandom_range(3));
      writedata = $urandom;
      case ($urandom_range(5))
        0, 1:    begin chipselect = 1'b1; write = 1'b1; end
        2:       begin chipselect = 1'b0; write = 1'b1; end
        3:       begin chipselect = 1'b1; write = 1'b0; end
        default: begin chipselect = 1'b0; write = 1'b0; end
      endcase
      reset = ($urandom_range(299) == 0);
      tick();
    end
    reset = 1'b0; chipselect = 1'b0; write = 1'b0;
    repeat (3) tick();

    @(posedge clk);
    #2;
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/arquitetura_button_pio.md
# arquitetura_button_pio

Parametrised Avalon-MM input port for the board push-buttons and switches, replacing the fixed 4-bit read-only button port. Each channel has a two-flop synchroniser, a per-channel debounce counter, configurable edge detection, a write-1-to-clear edge-capture register and a maskable level interrupt. It sits on the Nios II data bus and drives one IRQ line. Robot-control software can therefore react to debounced presses without polling.

## Interface
- WIDTH, 4: number of input channels, 1–32.
- DEBOUNCE_CYCLES, 50000: consecutive stable cycles required to accept a new level, ≥1 (1 ms at 50 MHz).
- EDGE_TYPE, 1: 0 = rising, 1 = falling, 2 = any edge of the debounced level sets capture.
- IDLE_LEVEL, 1: reset value of the synchroniser and debounced state, replicated across all bits. Buttons are active-low.
- clk  in  1  system clock; one clock, all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- address  in  2  register select.
- chipselect  in  1  slave select.
- write  in  1  write strobe, qualified by chipselect.
- writedata  in  32  write data, bits [WIDTH-1:0] used.
- in_port  in  WIDTH  asynchronous raw inputs.
- readdata  out  32  registered read data, upper bits zero.
- irq  out  1  registered level interrupt.

## Operation
- Register map:
  - 0 = debounced data (RO).
  - 1 = irq mask (RW).
  - 2 = raw synchronised input (RO, debug).
  - 3 = edge capture (read; write 1 clears).
- readdata is reloaded every clock from the addressed register, with no read strobe. Read latency is 1 cycle.
- Writes to addresses 0 and 2 are ignored.
- Synchroniser: sync1 <= in_port; sync2 <= sync1.
- Debounce, per bit, counter width clog2(DEBOUNCE_CYCLES)+1:
  - If sync2 == stable: counter <= 0.
  - Else if counter == DEBOUNCE_CYCLES-1: stable <= sync2 and counter <= 0. This is the "accept" event.
  - Else: counter <= counter+1.
  - Any return of sync2 to stable before accept restarts the count. Glitches shorter than DEBOUNCE_CYCLES never reach stable.
- Edge capture: a bit sets on the accept clock when the new stable value matches EDGE_TYPE.
  - A CPU write-1 to address 3 clears the selected bits.
  - If set and clear hit the same bit on the same cycle, set wins.
- irq <= |(edge_capture & mask). The output is level-type and stays high until every unmasked capture bit is cleared or masked.
- Reset loads:
  - sync1, sync2 and stable = {WIDTH{IDLE_LEVEL}}.
  - counters, mask and edge_capture = 0.
  - readdata = 0, irq = 0.
- Reset asserted mid-count discards the count. No edge is captured from reset release itself.

## Timing
- in_port change held from cycle t: sync2 shows it after edge t+2.
- stable and the edge_capture bit update at edge t+2+DEBOUNCE_CYCLES.
- irq rises one edge later, at t+3+DEBOUNCE_CYCLES, if the bit is masked-in.
- readdata reflects the new value at the edge after the address is presented.
- Mask write at edge w: irq reflects the new mask at edge w+1.
- Capture clear at edge w: irq falls at edge w+1, unless a new capture set occurs at w.
- Channels are fully independent. Simultaneous accepts on several bits all capture in the same cycle.

## Test plan
All scenarios use WIDTH=4, DEBOUNCE_CYCLES=4, EDGE_TYPE=1, IDLE_LEVEL=1.
- Reset, then read address 0 -> readdata=0x0000000F; irq=0; address 3 reads 0x0.
- in_port=0xE held, mask=0x1 -> address 0 reads 0xE after 6 edges; capture=0x1; irq=1 on the following edge.
- 3-cycle low pulse on bit1, then return high -> stable stays 0xF; capture=0x0; irq stays 0.
- Capture=0x3, write 0x1 to address 3 -> reads 0x2. In the same cycle, accept a new falling edge on bit0 with a write of 0x1 -> bit0 remains set.
- Capture=0x4 with mask=0x0 -> irq=0. Write mask=0x4 -> irq=1 next edge. Write 0x4 to address 3 -> irq=0 next edge.
- Assert reset midway through a debounce count on bit2 -> after release, stable=0xF and capture=0. A held low input then needs a full 6 edges to be accepted.
